vga_sync_monitor: RTL and testbench

Receive-side counterpart of the VGA 640x480 sync generator. Samples an hsync/vsync/rgb stream on the pixel tick, measures line and frame timing, locks to the expected 800x525 raster, and recovers pixel coordinates plus a pixel-valid stream. It is a device-bus peripheral, so software can read status and error counts and probe one pixel's colour. It sits beside the generator for on-chip loopback checking, or in front of any sink that needs pixel coordinates.

---
 rtl/vga_sync_monitor.sv | 243 ++++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// VGA receive-side monitor: measures hsync/vsync timing, locks to the expected raster,
// recovers pixel coordinates and exposes status, error count and a colour probe on a device bus.
module vga_sync_monitor #(
  parameter int CD          = 12,
  parameter int HD          = 640,
  parameter int HF          = 16,
  parameter int HB          = 48,
  parameter int HR          = 96,
  parameter int VD          = 480,
  parameter int VF          = 10,
  parameter int VB          = 33,
  parameter int VR          = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_tick,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [CD-1:0]        rgb,
  input  logic                 device_req_i,
  input  logic                 device_we_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  output logic [10:0]          px_x,
  output logic [10:0]          px_y,
  output logic [CD-1:0]        px_rgb,
  output logic                 px_valid,
  output logic                 locked
);

  localparam logic [10:0] HT_W   = 11'(HD + HF + HB + HR);
  localparam logic [10:0] VT_W   = 11'(VD + VF + VB + VR);
  localparam logic [10:0] HD_W   = 11'(HD);
  localparam logic [10:0] VD_W   = 11'(VD);
  localparam logic [10:0] HLOAD  = 11'(HD + HF);
  localparam logic [10:0] VLOAD  = 11'(VD + VF);
  localparam logic [10:0] CNTMAX = 11'h7FF;
  localparam logic [3:0]  LF_W   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  state_bits;
  logic [3:0]  good_cnt, good_cnt_nx;
  logic        err_inc;

  logic        hs_prev, vs_prev;
  logic        hs_fall, vs_fall;
  logic [10:0] hcnt, lcnt, line_len, frame_len;
  logic [10:0] line_len_new, lcnt_new;
  logic        frame_bad, line_bad, frame_good, sync_lost;
  logic [10:0] hpos, vpos;
  logic        h_wrap;

  logic [10:0]    probe_x, probe_y;
  logic [CD-1:0]  probe_rgb;
  logic           probe_hit;
  logic [15:0]    err_cnt;

  logic                 wr, wr_err, wr_probe;
  logic [DataWidth-1:0] rd_mux;
  logic                 unused_bits;

  assign unused_bits = ^{device_be_i, device_addr_i[AddrWidth-1:5], device_addr_i[1:0],
                         device_wdata_i[DataWidth-1:27], device_wdata_i[15:11]};

  assign hs_fall = pix_tick & hs_prev & ~hsync;
  assign vs_fall = pix_tick & vs_prev & ~vsync;

  assign line_len_new = (hcnt == CNTMAX) ? CNTMAX : hcnt + 11'd1;
  assign lcnt_new     = (hs_fall && lcnt != CNTMAX) ? lcnt + 11'd1 : lcnt;
  assign line_bad     = hs_fall && (line_len_new != HT_W);
  // A bad line on the closing tick still spoils the frame it ends.
  assign frame_good   = (lcnt_new == VT_W) && !frame_bad && !line_bad;
  assign sync_lost    = pix_tick && !hs_fall && (hcnt == CNTMAX - 11'd1);
  assign h_wrap       = !hs_fall && (hpos == HT_W - 11'd1);

  assign wr       = device_req_i & device_we_i;
  assign wr_err   = wr && (device_addr_i[4:2] == 3'd3);
  assign wr_probe = wr && (device_addr_i[4:2] == 3'd4);

  assign locked     = (state == LOCKED);
  assign state_bits = state;

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    err_inc     = 1'b0;
    if (sync_lost) begin
      state_nx    = SEARCH;
      good_cnt_nx = 4'd0;
      err_inc     = 1'b1;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state_nx    = CHECK;
            good_cnt_nx = 4'd0;
          end
        end
        CHECK: begin
          if (vs_fall) begin
            if (frame_good) begin
              good_cnt_nx = good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LF_W) state_nx = LOCKED;
            end else begin
              good_cnt_nx = 4'd0;
              err_inc     = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (vs_fall && !frame_good)) begin
            state_nx    = CHECK;
            good_cnt_nx = 4'd0;
            err_inc     = 1'b1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= 4'd0;
      err_cnt  <= 16'd0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
      if (wr_err) err_cnt <= 16'd0;
      else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev   <= 1'b1;
      vs_prev   <= 1'b1;
      hcnt      <= '0;
      lcnt      <= '0;
      line_len  <= '0;
      frame_len <= '0;
      frame_bad <= 1'b0;
      hpos      <= '0;
      vpos      <= '0;
      px_x      <= '0;
      px_y      <= '0;
      px_rgb    <= '0;
      px_valid  <= 1'b0;
      probe_x   <= '0;
      probe_y   <= '0;
      probe_rgb <= '0;
      probe_hit <= 1'b0;
    end else begin
      px_valid <= 1'b0;
      if (pix_tick) begin
        hs_prev <= hsync;
        vs_prev <= vsync;

        if (hs_fall) begin
          hcnt     <= '0;
          line_len <= line_len_new;
          if (line_bad) frame_bad <= 1'b1;
        end else if (hcnt != CNTMAX) begin
          hcnt <= hcnt + 11'd1;
        end

        if (vs_fall) begin
          frame_len <= lcnt_new;
          lcnt      <= '0;
          frame_bad <= 1'b0;
        end else begin
          lcnt <= lcnt_new;
        end

        if (hs_fall) hpos <= HLOAD;
        else if (h_wrap) hpos <= '0;
        else hpos <= hpos + 11'd1;

        if (vs_fall) vpos <= VLOAD;
        else if (h_wrap) vpos <= (vpos == VT_W - 11'd1) ? 11'd0 : vpos + 11'd1;

        if (state == LOCKED && hpos < HD_W && vpos < VD_W) begin
          px_valid <= 1'b1;
          px_x     <= hpos;
          px_y     <= vpos;
          px_rgb   <= rgb;
        end

        if (state == LOCKED && hpos == probe_x && vpos == probe_y && !wr_probe) begin
          probe_rgb <= rgb;
          probe_hit <= 1'b1;
        end
      end

      if (wr_probe) begin
        probe_x   <= device_wdata_i[10:0];
        probe_y   <= device_wdata_i[26:16];
        probe_hit <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (device_addr_i[4:2])
      3'd0: rd_mux[7:0] = {good_cnt, state_bits, probe_hit, locked};
      3'd1: rd_mux[10:0] = line_len;
      3'd2: rd_mux[10:0] = frame_len;
      3'd3: rd_mux[15:0] = err_cnt;
      3'd4: begin
        rd_mux[10:0]  = probe_x;
        rd_mux[26:16] = probe_y;
      end
      3'd5: rd_mux[CD-1:0] = probe_rgb;
      default: rd_mux = '0;
    endcase
  end

  // Every request gets exactly one response a cycle later; writes return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced raster; a built-in generator drives the
// stream while queues hold expected pixel and bus responses until the DUT produces them.
module tb_vga_sync_monitor;

  localparam int CD = 12;
  localparam int HD = 16, HF = 2, HB = 3, HR = 4;
  localparam int VD = 8, VF = 1, VB = 2, VR = 1;
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int LOCK_FRAMES = 2;

  logic          clk = 1'b0;
  logic          reset, pix_tick, hsync, vsync;
  logic [CD-1:0] rgb;
  logic          req, we;
  logic [31:0]   addr, wdata;
  logic [3:0]    be;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [10:0]   px_x, px_y;
  logic [CD-1:0] px_rgb;
  logic          px_valid, locked;

  int total = 0;
  int bad   = 0;

  int   hc, vc;
  logic hold_hi;
  logic sb_en;
  logic req_prev = 1'b0;

  typedef struct packed {
    logic [10:0]   x;
    logic [10:0]   y;
    logic [CD-1:0] c;
  } px_t;
  px_t         px_q[$];
  string       tag_q[$];
  logic [31:0] exp_q[$];

  int          px_count;
  logic [10:0] first_x, first_y, last_x, last_y;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .CD(CD), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR),
    .LOCK_FRAMES(LOCK_FRAMES), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .device_req_i(req), .device_we_i(we), .device_addr_i(addr), .device_be_i(be),
    .device_wdata_i(wdata), .device_rvalid_o(rvalid), .device_rdata_o(rdata),
    .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb), .px_valid(px_valid), .locked(locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CD-1:0] rgb_of(input int h, input int v);
    logic [5:0] a, b;
    a = h[5:0];
    b = v[5:0];
    if (h < HD && v < VD) return {a, b};
    return '0;
  endfunction

  // One pixel tick (optionally with a same-cycle bus write), then an idle clock.
  task automatic drive_tick(input logic adv, input logic wr_en,
                            input logic [31:0] waddr, input logic [31:0] wval);
    int ph, pv;
    pix_tick = 1'b1;
    hsync    = hold_hi | !(hc >= HD + HF && hc < HD + HF + HR);
    vsync    = hold_hi | !(vc >= VD + VF && vc < VD + VF + VR);
    rgb      = rgb_of(hc, vc);
    if (sb_en) begin
      ph = (hc == 0) ? HT - 1 : hc - 1;
      pv = (hc == 0) ? ((vc == 0) ? VT - 1 : vc - 1) : vc;
      if (ph < HD && pv < VD) px_q.push_back(px_t'{11'(ph), 11'(pv), rgb});
    end
    if (wr_en) begin
      req = 1'b1; we = 1'b1; addr = waddr; wdata = wval;
      tag_q.push_back("wr_tick_rsp");
      exp_q.push_back(32'd0);
    end
    @(posedge clk); @(negedge clk);
    pix_tick = 1'b0; req = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
    if (adv) begin
      if (hc == HT - 1) begin
        hc = 0;
        vc = (vc == VT - 1) ? 0 : vc + 1;
      end else begin
        hc = hc + 1;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick(1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(hc == h && vc == v) && n < HT * VT + 2) begin
      ticks(1);
      n++;
    end
    check("run_to_reached", {31'd0, (hc == h && vc == v)}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    req = 1'b1; we = 1'b0; addr = a;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(posedge clk); @(negedge clk);
    req = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tag_q.push_back("wr_rsp");
    exp_q.push_back(32'd0);
    @(posedge clk); @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  always @(posedge clk) req_prev <= req;

  always @(negedge clk) begin
    if (rvalid || req_prev) check("rvalid_timing", {31'd0, rvalid}, {31'd0, req_prev});
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        check("rsp_extra", {31'd0, rvalid}, 32'd0);
      end else begin
        string t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, rdata, e);
      end
    end
  end

  always @(negedge clk) begin
    if (px_valid && sb_en) begin
      if (px_q.size() == 0) begin
        check("px_extra", {31'd0, px_valid}, 32'd0);
      end else begin
        px_t p;
        p = px_q.pop_front();
        check("px_x", {21'd0, px_x}, {21'd0, p.x});
        check("px_y", {21'd0, px_y}, {21'd0, p.y});
        check("px_rgb", {20'd0, px_rgb}, {20'd0, p.c});
        if (px_count == 0) begin
          first_x = px_x;
          first_y = px_y;
        end
        last_x = px_x;
        last_y = px_y;
        px_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] A_STATUS = 32'h00, A_LINE = 32'h04, A_FRAME = 32'h08;
  localparam logic [31:0] A_ERR = 32'h0C, A_PXY = 32'h10, A_PRGB = 32'h14;
  localparam logic [31:0] PROBE_VAL = (32'd3 << 16) | 32'd5;

  initial begin
    reset = 1'b1; pix_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;
    hc = 0; vc = 0; hold_hi = 1'b0; sb_en = 1'b0; px_count = 0;
    first_x = '0; first_y = '0; last_x = '0; last_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_px_valid", {31'd0, px_valid}, 32'd0);
    check("rst_px_x", {21'd0, px_x}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    bus_read(A_STATUS, 32'h00, "rst_status");
    bus_read(A_LINE, 32'd0, "rst_line_len");
    bus_read(A_ERR, 32'd0, "rst_err_cnt");

    // First vsync fall moves SEARCH -> CHECK.
    run_to(0, VD + VF); ticks(1);
    bus_read(A_STATUS, 32'h04, "status_after_vs1");

    run_to(0, VD + VF); ticks(1);
    bus_read(A_STATUS, 32'h14, "status_after_vs2");
    bus_read(A_LINE, HT, "line_len");
    bus_read(A_FRAME, VT, "frame_len");

    run_to(0, VD + VF); ticks(1);
    check("locked_after_vs3", {31'd0, locked}, 32'd1);
    bus_read(A_STATUS, 32'h29, "status_locked");
    bus_read(A_ERR, 32'd0, "err_clean");

    // One full locked frame through the pixel scoreboard, with the probe armed.
    bus_write(A_PXY, PROBE_VAL);
    run_to(0, 0);
    sb_en = 1'b1;
    ticks(HT * VT);
    sb_en = 1'b0;
    check("px_count", px_count, HD * VD);
    check("px_first", {5'd0, first_y, 5'd0, first_x}, 32'd0);
    check("px_last", {5'd0, last_y, 5'd0, last_x}, {16'(VD - 1), 16'(HD - 1)});
    check("px_q_empty", px_q.size(), 32'd0);
    bus_read(A_STATUS, 32'h2B, "status_probe_hit");
    bus_read(A_PRGB, {20'd0, rgb_of(6, 3)}, "probe_rgb");
    bus_write(A_PXY, PROBE_VAL);
    bus_read(A_STATUS, 32'h29, "status_probe_cleared");
    bus_read(A_PXY, PROBE_VAL, "probe_xy");

    // Stretch line 2 by one tick; its closing hsync fall must drop lock.
    run_to(0, 2);
    drive_tick(1'b0, 1'b0, 32'd0, 32'd0);
    run_to(HD + HF, 2); ticks(1);
    check("unlocked_after_stretch", {31'd0, locked}, 32'd0);
    bus_read(A_STATUS, 32'h04, "status_after_stretch");
    bus_read(A_ERR, 32'd1, "err_after_stretch");
    bus_read(A_LINE, HT + 1, "line_len_stretch");

    // Bad-frame error at this vsync fall coincides with an ERR_CNT write.
    run_to(0, VD + VF);
    drive_tick(1'b1, 1'b1, A_ERR, 32'hFFFF_FFFF);
    bus_read(A_ERR, 32'd0, "err_write_beats_inc");
    bus_read(A_STATUS, 32'h04, "status_bad_frame");
    bus_read(A_LINE, HT, "line_len_rvalid_next");

    run_to(0, VD + VF); ticks(1);
    bus_read(A_STATUS, 32'h14, "status_relock_1");
    run_to(0, VD + VF); ticks(1);
    check("relocked", {31'd0, locked}, 32'd1);
    bus_read(A_STATUS, 32'h29, "status_relocked");
    bus_read(A_ERR, 32'd0, "err_after_relock");
    bus_read(A_FRAME, VT, "frame_len_relock");

    // Sync loss: both syncs held high long enough for hcnt to saturate.
    hold_hi = 1'b1;
    ticks(2100);
    run_to(0, 0);
    check("unlocked_sync_lost", {31'd0, locked}, 32'd0);
    bus_write(A_PXY, PROBE_VAL);
    bus_read(A_STATUS, 32'h00, "status_search");
    bus_read(A_ERR, 32'd1, "err_sync_lost_once");

    hold_hi = 1'b0;
    run_to(0, VD + VF); ticks(1);
    bus_read(A_STATUS, 32'h04, "status_recheck");
    bus_read(A_ERR, 32'd1, "err_no_search_errors");

    @(negedge clk); @(negedge clk);
    check("rsp_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
